qpsk_symbol_timer: RTL

Parametrised QPSK transmit symbol timer. It paces symbol reads from the TX FIFO by counting MSF carrier pulses, with a latched divisor. It starts on the first one-second marker after arming and can optionally re-align to every later marker. Compared with the earlier timing control, it adds:

- finite frame length,
- FIFO underrun detection,
- a status/symbol index.

It sits between the MSF carrier pulse / one_sec_marker logic and the clock converter feeding the FIFO's tready.

---
 rtl/qpsk_tx_pkg.sv | 19 +
 rtl/qpsk_symbol_timer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/qpsk_tx_pkg.sv
// rtl/qpsk_tx_pkg.sv - shared types and constants for the QPSK transmit path
//
// Contents:
//   qpsk_state_t      2-bit symbol timer state (IDLE, ARMED, RUN, DONE)
//   MSF_CP_FRANKFURT  carrier pulses per symbol for the Frankfurt carrier
//   MSF_CP_RUGBY      carrier pulses per symbol for the Rugby carrier
package qpsk_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } qpsk_state_t;

    localparam int unsigned MSF_CP_FRANKFURT = 3100;
    localparam int unsigned MSF_CP_RUGBY     = 2400;

endpackage

// File: rtl/qpsk_symbol_timer.sv
// rtl/qpsk_symbol_timer.sv - QPSK transmit symbol timer paced by MSF carrier pulses
//
// Paces symbol reads from the TX FIFO. It starts on the first second marker
// after arming, issues one strobe every cp_per_symbol carrier pulses, and
// optionally re-aligns on later markers. It also supports a finite frame
// length and flags FIFO underrun.
//
// Parameters:
//   CNT_W    carrier counter width
//   FRAME_W  symbol index / frame length width
//   RESYNC   1 = re-align on every marker while running, 0 = first marker only
//
// Ports:
//   clk                  system clock, rising edge
//   rst                  synchronous active-high reset
//   msf_carrier_pulse    one-cycle carrier tick
//   one_sec_pulse        second marker, qualified by msf_carrier_pulse
//   cp_per_symbol        carrier pulses per symbol, sampled on arming (0 acts as 1)
//   frame_len            symbols per frame, sampled on arming (0 = continuous)
//   qpsk_enable          level: 1 = run, 0 = abort to IDLE
//   symbol_valid         FIFO has data
//   msf_carrier_counter  carrier count within the current symbol
//   next_output          one-cycle symbol strobe (tready request)
//   qpsk_go              high while running
//   symbol_index         strobes issued in this frame
//   frame_done           one-cycle pulse on frame completion
//   underrun             sticky: a strobe was issued with symbol_valid low
module qpsk_symbol_timer
    import qpsk_tx_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int FRAME_W = 12,
    parameter bit RESYNC  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               msf_carrier_pulse,
    input  logic               one_sec_pulse,
    input  logic [CNT_W-1:0]   cp_per_symbol,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic               qpsk_enable,
    input  logic               symbol_valid,
    output logic [CNT_W-1:0]   msf_carrier_counter,
    output logic               next_output,
    output logic               qpsk_go,
    output logic [FRAME_W-1:0] symbol_index,
    output logic               frame_done,
    output logic               underrun
);

    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [FRAME_W-1:0] IDX_ONE = FRAME_W'(1);

    qpsk_state_t        state;
    logic [CNT_W-1:0]   cp_last;      // latched divisor minus one
    logic [FRAME_W-1:0] frame_len_q;
    logic               sym_boundary;
    logic               frame_end;

    // A marker realign takes priority over the wrap; both land on count 0,
    // so a marker coinciding with a wrap still yields a single strobe.
    assign sym_boundary = (RESYNC && one_sec_pulse) || (msf_carrier_counter == cp_last);

    // Boundary that would issue strobe frame_len+1 ends the frame instead.
    assign frame_end = (frame_len_q != '0) && (symbol_index == frame_len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            cp_last             <= '0;
            frame_len_q         <= '0;
            msf_carrier_counter <= '0;
            next_output         <= 1'b0;
            qpsk_go             <= 1'b0;
            symbol_index        <= '0;
            frame_done          <= 1'b0;
            underrun            <= 1'b0;
        end else begin
            next_output <= 1'b0;
            frame_done  <= 1'b0;

            if (!qpsk_enable) begin
                // Abort: counter and symbol_index stay for inspection.
                state   <= ST_IDLE;
                qpsk_go <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state        <= ST_ARMED;
                        // A divisor of 0 behaves as 1: compare value is 0 either way.
                        cp_last      <= (cp_per_symbol == '0) ? '0 : cp_per_symbol - CNT_ONE;
                        frame_len_q  <= frame_len;
                        underrun     <= 1'b0;
                        symbol_index <= '0;
                    end

                    ST_ARMED: begin
                        if (msf_carrier_pulse && one_sec_pulse) begin
                            state               <= ST_RUN;
                            msf_carrier_counter <= '0;
                            next_output         <= 1'b1;
                            qpsk_go             <= 1'b1;
                            symbol_index        <= IDX_ONE;
                            if (!symbol_valid) begin
                                underrun <= 1'b1;
                            end
                        end
                    end

                    ST_RUN: begin
                        if (msf_carrier_pulse) begin
                            if (sym_boundary) begin
                                msf_carrier_counter <= '0;
                                if (frame_end) begin
                                    state      <= ST_DONE;
                                    frame_done <= 1'b1;
                                    qpsk_go    <= 1'b0;
                                end else begin
                                    // Strobe is never stalled by an empty FIFO.
                                    next_output  <= 1'b1;
                                    symbol_index <= symbol_index + IDX_ONE;
                                    if (!symbol_valid) begin
                                        underrun <= 1'b1;
                                    end
                                end
                            end else begin
                                msf_carrier_counter <= msf_carrier_counter + CNT_ONE;
                            end
                        end
                    end

                    ST_DONE: begin
                        // Hold until qpsk_enable falls.
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
